// File: rtl/pwm_capture.sv
// PWM pulse-train capture: measures high time and period (in clk cycles) of an
// asynchronous input, strobing each complete period and flagging a stuck input.
module pwm_capture #(
    parameter int CBITS = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CBITS-1:0] high_time,
    output logic [CBITS-1:0] period,
    output logic [2:0]       code,
    output logic             meas_valid,
    output logic             stuck_high,
    output logic             stuck_low
);

    typedef enum logic [1:0] {
        WAIT_RISE,
        HIGH,
        LOW
    } state_t;

    localparam logic [CBITS-1:0] CNT_MAX = '1;
    localparam logic [CBITS-1:0] CNT_ONE = CBITS'(1);

    state_t           state;
    logic             s1, s2, s3;
    logic [CBITS-1:0] hcnt, pcnt;
    logic             rise, fall;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // NOTE: every register here is state, so all updates are non-blocking and
    // the synchronizer flops are cleared by reset along with the counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= WAIT_RISE;
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            hcnt       <= '0;
            pcnt       <= '0;
            high_time  <= '0;
            period     <= '0;
            code       <= '0;
            meas_valid <= 1'b0;
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
        end else begin
            s1         <= pwm_in;
            s2         <= s1;
            s3         <= s2;
            meas_valid <= 1'b0;

            case (state)
                WAIT_RISE: begin
                    if (rise) begin
                        state      <= HIGH;
                        hcnt       <= CNT_ONE;
                        pcnt       <= CNT_ONE;
                        stuck_high <= 1'b0;
                        stuck_low  <= 1'b0;
                    end
                end

                // Saturation is tested before the edge so pcnt can never wrap
                // and the largest reported period stays at CNT_MAX-1.
                HIGH: begin
                    if (pcnt == CNT_MAX) begin
                        state      <= WAIT_RISE;
                        stuck_high <= 1'b1;
                        stuck_low  <= 1'b0;
                        hcnt       <= '0;
                        pcnt       <= '0;
                    end else if (fall) begin
                        state <= LOW;
                        pcnt  <= pcnt + CNT_ONE;
                    end else begin
                        hcnt <= hcnt + CNT_ONE;
                        pcnt <= pcnt + CNT_ONE;
                    end
                end

                LOW: begin
                    if (pcnt == CNT_MAX) begin
                        state      <= WAIT_RISE;
                        stuck_low  <= 1'b1;
                        stuck_high <= 1'b0;
                        hcnt       <= '0;
                        pcnt       <= '0;
                    end else if (rise) begin
                        state      <= HIGH;
                        high_time  <= hcnt;
                        period     <= pcnt;
                        code       <= hcnt[11:9];
                        meas_valid <= 1'b1;
                        hcnt       <= CNT_ONE;
                        pcnt       <= CNT_ONE;
                    end else begin
                        pcnt <= pcnt + CNT_ONE;
                    end
                end

                default: state <= WAIT_RISE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: table of PWM waveforms plus hand-written
// sequences for reset, stuck-high and stuck-low behaviour.
module tb_pwm_capture;

    localparam int CBITS = 14;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pwm_in = 1'b0;
    logic [CBITS-1:0] high_time;
    logic [CBITS-1:0] period;
    logic [2:0]       code;
    logic             meas_valid;
    logic             stuck_high;
    logic             stuck_low;

    pwm_capture #(.CBITS(CBITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .high_time  (high_time),
        .period     (period),
        .code       (code),
        .meas_valid (meas_valid),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Strobe monitor: counts strobes, records the values seen on the last one
    // and the longest run of consecutive strobe cycles.
    int strobes;
    int last_h, last_p, last_c;
    int run, max_run;

    always @(negedge clk) begin
        if (meas_valid) begin
            strobes = strobes + 1;
            last_h  = int'(high_time);
            last_p  = int'(period);
            last_c  = int'(code);
            run     = run + 1;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    typedef struct {
        int high;
        int per;
        int reps;
        int exp_strobes;
        int exp_high;
        int exp_per;
        int exp_code;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic val, input int n);
        pwm_in = val;
        tick(n);
    endtask

    task automatic clear_mon();
        strobes = 0;
        last_h  = -1;
        last_p  = -1;
        last_c  = -1;
        run     = 0;
        max_run = 0;
    endtask

    task automatic apply_reset();
        pwm_in = 1'b0;
        rst_n  = 1'b0;
        tick(2);
        rst_n  = 1'b1;
        clear_mon();
        tick(2);
    endtask

    // A closing 1-cycle pulse provides the rise that completes the last period.
    task automatic close_period();
        drive(1'b1, 1);
        drive(1'b0, 4);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_high_time"}, high_time, 0);
        check({tag, "_period"}, period, 0);
        check({tag, "_code"}, code, 0);
        check({tag, "_meas_valid"}, meas_valid, 0);
        check({tag, "_stuck_high"}, stuck_high, 0);
        check({tag, "_stuck_low"}, stuck_low, 0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{768,   8192,  2, 2, 768,   8192,  1};
        vecs[1] = '{7936,  8192,  1, 1, 7936,  8192,  7};
        vecs[2] = '{1,     4,     5, 5, 1,     4,     0};
        vecs[3] = '{1280,  2000,  1, 1, 1280,  2000,  2};
        vecs[4] = '{2560,  2600,  1, 1, 2560,  2600,  5};
        vecs[5] = '{512,   600,   1, 1, 512,   600,   1};
        vecs[6] = '{100,   16382, 1, 1, 100,   16382, 0};

        clear_mon();
        @(posedge clk);
        #1;
        tick(2);
        check_zero("reset");
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 7; i++) begin
            apply_reset();
            for (int r = 0; r < vecs[i].reps; r++) begin
                drive(1'b1, vecs[i].high);
                drive(1'b0, vecs[i].per - vecs[i].high);
            end
            close_period();
            check($sformatf("v%0d_strobes", i), strobes, vecs[i].exp_strobes);
            check($sformatf("v%0d_high_time", i), last_h, vecs[i].exp_high);
            check($sformatf("v%0d_period", i), last_p, vecs[i].exp_per);
            check($sformatf("v%0d_code", i), last_c, vecs[i].exp_code);
            check($sformatf("v%0d_pulse_len", i), max_run, 1);
            check($sformatf("v%0d_held_period", i), period, vecs[i].exp_per);
            check($sformatf("v%0d_stuck", i), {stuck_high, stuck_low}, 0);
        end

        // Stuck high: saturation lands on the 16386th edge sampling pwm high.
        apply_reset();
        drive(1'b1, 16385);
        check("sh_before_sat", stuck_high, 0);
        drive(1'b1, 1);
        check("sh_at_sat", stuck_high, 1);
        check("sh_no_low", stuck_low, 0);
        check("sh_no_strobe", strobes, 0);
        drive(1'b0, 4);
        check("sh_held", stuck_high, 1);
        drive(1'b1, 3);
        check("sh_cleared", stuck_high, 0);
        drive(1'b1, 2);
        drive(1'b0, 15);
        close_period();
        check("sh_after_strobes", strobes, 1);
        check("sh_after_high", last_h, 5);
        check("sh_after_period", last_p, 20);

        // Stuck low: one full period, then a rise and fall and pwm held low.
        apply_reset();
        drive(1'b1, 3);
        drive(1'b0, 7);
        drive(1'b1, 3);
        drive(1'b0, 16382);
        check("sl_before_sat", stuck_low, 0);
        drive(1'b0, 1);
        check("sl_at_sat", stuck_low, 1);
        check("sl_no_high", stuck_high, 0);
        check("sl_strobes", strobes, 1);
        check("sl_high_time", high_time, 3);
        check("sl_period", period, 10);
        drive(1'b1, 3);
        check("sl_cleared", stuck_low, 0);
        drive(1'b0, 2);

        // Reset for one cycle in the middle of a high phase.
        apply_reset();
        drive(1'b1, 4);
        drive(1'b0, 6);
        drive(1'b1, 5);
        check("mr_pre_high_time", high_time, 4);
        rst_n = 1'b0;
        tick(1);
        check_zero("mr");
        rst_n = 1'b1;
        clear_mon();
        drive(1'b1, 3);
        check("mr_first_rise", strobes, 0);
        drive(1'b0, 7);
        close_period();
        check("mr_strobes", strobes, 1);
        check("mr_high_time", last_h, 3);
        check("mr_period", last_p, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
